// File: rtl/bf16_out_pack_if.sv
// Stream bundle for bf16_out_pack: fp32 element input and packed bf16 word output.
interface bf16_out_pack_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_keep;
   logic        out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last
   );
endinterface

// File: rtl/bf16_out_pack.sv
// fp32 -> bf16 (RNE, optional ReLU) converter that packs element pairs
// into 32-bit words and buffers them in a small FIFO.
module bf16_out_pack #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             relu_en,
   bf16_out_pack_if.slave   s,
   output logic [CNT_W-1:0] word_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 35;

   typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [15:0]      lo_q, lo_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [EW-1:0]    mem_q [DEPTH];
   logic [EW-1:0]    mem_d [DEPTH];

   logic        accept;
   logic        pop;
   logic        push;
   logic [31:0] w_data;
   logic [1:0]  w_keep;
   logic        w_last;
   logic [31:0] rnd;
   logic [15:0] bf;
   logic [EW-1:0] head;

   assign s.in_ready = (count_q < CW'(DEPTH)) & ~clr;
   assign accept     = s.in_valid & s.in_ready;
   assign s.out_valid = (count_q != '0);
   assign pop        = s.out_valid & s.out_ready & ~clr;
   assign word_cnt   = cnt_q;

   // ReLU beats Inf/NaN passthrough, which beats rounding overflow
   always_comb begin
      rnd = s.in_data + 32'h0000_7FFF + {31'b0, s.in_data[16]};
      if (relu_en & s.in_data[31])
         bf = 16'h0000;
      else if (s.in_data[30:23] == 8'hFF)
         bf = s.in_data[31:16];
      else if (rnd[30:23] == 8'hFF)
         bf = {s.in_data[31], 15'h7F7F};
      else
         bf = rnd[31:16];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: if (accept & ~s.in_last) state_d = HALF;
         HALF:  if (accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
      if (clr) state_d = EMPTY;
   end

   always_comb begin
      push   = 1'b0;
      w_data = '0;
      w_keep = '0;
      w_last = 1'b0;
      lo_d   = lo_q;
      unique case (state_q)
         EMPTY: begin
            if (accept & s.in_last) begin
               push   = 1'b1;
               w_data = {16'h0000, bf};
               w_keep = 2'b01;
               w_last = 1'b1;
            end else if (accept) begin
               lo_d = bf;
            end
         end
         HALF: begin
            if (accept) begin
               push   = 1'b1;
               w_data = {bf, lo_q};
               w_keep = 2'b11;
               w_last = s.in_last;
            end
         end
         default: push = 1'b0;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      cnt_d    = cnt_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = {w_data, w_keep, w_last};
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d    = cnt_q + CNT_W'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lo_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cnt_q    <= '0;
         mem_q    <= '{default: '0};
      end else begin
         lo_q     <= lo_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
      end
   end

   assign head       = mem_q[rd_ptr_q];
   assign s.out_data = s.out_valid ? head[34:3] : '0;
   assign s.out_keep = s.out_valid ? head[2:1]  : '0;
   assign s.out_last = s.out_valid ? head[0]    : 1'b0;
endmodule
